// File: rtl/bcd_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_subtractor
// Purpose  : Digit-serial packed-BCD subtractor returning sign and magnitude.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  neg,
    output logic                  err
);

    localparam int c_W  = 4 * DIGITS;
    localparam int c_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(DIGITS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SUB  = 2'd1;
    localparam logic [1:0] c_NEG  = 2'd2;
    localparam logic [1:0] c_ERR  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [c_W-1:0]  a_q, a_d;
    logic [c_W-1:0]  b_q, b_d;
    logic [c_W-1:0]  r_q, r_d;
    logic [c_IW-1:0] idx_q, idx_d;
    logic            borrow_q, borrow_d;
    logic [c_W-1:0]  diff_q, diff_d;
    logic            neg_q, neg_d;
    logic            err_q, err_d;
    logic            done_q, done_d;

    logic [3:0]        w_a_dig [DIGITS];
    logic [3:0]        w_b_dig [DIGITS];
    logic [3:0]        w_r_dig [DIGITS];
    logic [DIGITS-1:0] w_in_bad;
    logic              w_any_bad;
    logic [3:0]        w_min;
    logic [3:0]        w_sub;
    logic [4:0]        w_t;
    logic [3:0]        w_digit;
    logic              w_borrow_new;
    logic              w_last;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_a_dig[gi]  = a_q[4*gi +: 4];
            assign w_b_dig[gi]  = b_q[4*gi +: 4];
            assign w_r_dig[gi]  = r_q[4*gi +: 4];
            assign w_in_bad[gi] = (a[4*gi +: 4] > 4'd9) || (b[4*gi +: 4] > 4'd9);
        end
    endgenerate

    assign w_any_bad = |w_in_bad;

    // The fix-up pass reuses the same digit subtractor with a zero minuend.
    assign w_min        = (state_q == c_NEG) ? 4'd0 : w_a_dig[idx_q];
    assign w_sub        = (state_q == c_NEG) ? w_r_dig[idx_q] : w_b_dig[idx_q];
    assign w_t          = {1'b0, w_min} - {1'b0, w_sub} - {4'd0, borrow_q};
    assign w_borrow_new = w_t[4];
    assign w_digit      = w_t[4] ? (w_t[3:0] + 4'd10) : w_t[3:0];
    assign w_last       = (idx_q == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= c_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    state_d = w_any_bad ? c_ERR : c_SUB;
                end
            end
            c_SUB: begin
                if (w_last) begin
                    state_d = w_borrow_new ? c_NEG : c_IDLE;
                end
            end
            c_NEG: begin
                if (w_last) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        neg_d    = neg_q;
        err_d    = err_q;
        done_d   = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    r_d      = '0;
                    idx_d    = '0;
                    borrow_d = 1'b0;
                end
            end
            c_SUB, c_NEG: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (int'(idx_q) == i) begin
                        r_d[4*i +: 4] = w_digit;
                    end
                end
                borrow_d = w_borrow_new;
                idx_d    = idx_q + 1'b1;
                if (w_last) begin
                    idx_d = '0;
                    if ((state_q == c_NEG) || !w_borrow_new) begin
                        diff_d   = r_d;
                        neg_d    = (state_q == c_NEG);
                        err_d    = 1'b0;
                        done_d   = 1'b1;
                    end
                    borrow_d = 1'b0;
                end
            end
            default: begin
                diff_d = '0;
                neg_d  = 1'b0;
                err_d  = 1'b1;
                done_d = 1'b1;
            end
        endcase
    end

    assign busy = (state_q != c_IDLE);
    assign done = done_q;
    assign diff = diff_q;
    assign neg  = neg_q;
    assign err  = err_q;

endmodule
`default_nettype wire
